// File: rtl/sha256_block_sequencer.sv
// Sequences pre-padded 512-bit blocks through a single-block SHA-256 core and returns the final digest.
// Optional WAIT watchdog: define SEQ_TIMEOUT_EN.
module sha256_block_sequencer #(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic             s_blk_valid,
   output logic             s_blk_ready,
   input  logic [511:0]     s_blk_data,
   input  logic             s_blk_first,
   input  logic             s_blk_last,
   output logic             core_start,
   output logic             core_init,
   output logic [511:0]     core_block,
   input  logic             core_done,
   input  logic [255:0]     core_digest,
   output logic             m_dig_valid,
   input  logic             m_dig_ready,
   output logic [255:0]     m_dig_data,
   output logic [CNT_W-1:0] blk_count,
   output logic             busy,
   output logic             err_seq,
   output logic             timeout
);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

   state_t state;
   logic   msg_open;
   logic   last_q;
   logic   blk_accept;
   logic   first_eff;

   if (CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("sha256_block_sequencer: CNT_W and TIMEOUT_CYCLES must be >= 1");
   end

   assign blk_accept = s_blk_valid & s_blk_ready;
   assign first_eff  = s_blk_first | ~msg_open;
   assign busy       = (state != S_IDLE);

`ifdef SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] wait_cnt;
   logic            wait_expired;
   assign wait_expired = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // NOTE: every register here is updated with non-blocking assignments, so all
   // branches read pre-edge values no matter the statement order.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state       <= S_IDLE;
         msg_open    <= 1'b0;
         last_q      <= 1'b0;
         s_blk_ready <= 1'b0;
         core_start  <= 1'b0;
         core_init   <= 1'b0;
         // NOTE: the wide data registers are reset too, because they drive ports
         // that must read 0 while in reset; pure storage would not need it.
         core_block  <= '0;
         m_dig_valid <= 1'b0;
         m_dig_data  <= '0;
         blk_count   <= '0;
         err_seq     <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         wait_cnt    <= '0;
         timeout     <= 1'b0;
`endif
      end else begin
         core_start <= 1'b0;
         case (state)
            S_IDLE: begin
               s_blk_ready <= 1'b1;
               if (blk_accept) begin
                  s_blk_ready <= 1'b0;
                  core_start  <= 1'b1;
                  core_init   <= first_eff;
                  core_block  <= s_blk_data;
                  last_q      <= s_blk_last;
                  if (first_eff)
                     blk_count <= '0;
                  // first without an open chain is fine; first==msg_open is the error case
                  if (s_blk_first == msg_open)
                     err_seq <= 1'b1;
                  state <= S_START;
               end
            end
            S_START: begin
`ifdef SEQ_TIMEOUT_EN
               wait_cnt <= '0;
`endif
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (core_done) begin
                  if (blk_count != {CNT_W{1'b1}})
                     blk_count <= blk_count + 1'b1;
                  if (last_q) begin
                     m_dig_data  <= core_digest;
                     m_dig_valid <= 1'b1;
                     state       <= S_OUT;
                  end else begin
                     msg_open    <= 1'b1;
                     s_blk_ready <= 1'b1;
                     state       <= S_IDLE;
                  end
               end
`ifdef SEQ_TIMEOUT_EN
               else if (wait_expired) begin
                  timeout     <= 1'b1;
                  msg_open    <= 1'b0;
                  s_blk_ready <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
`endif
            end
            S_OUT: begin
               if (m_dig_ready) begin
                  m_dig_valid <= 1'b0;
                  msg_open    <= 1'b0;
                  s_blk_ready <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Self-checking bench: a behavioural SHA-256 core drives the sequencer; digests are
// checked against known vectors and a message-level SHA-256 model.
module tb_sha256_block_sequencer;

   localparam int CNT_W      = 16;
   localparam int TB_TIMEOUT = 16;

   localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [511:0] TWO_BLK0  = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO_BLK1  = {448'h0, 64'h1c0};
   localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   logic             aclk = 1'b0;
   logic             areset;
   logic             s_blk_valid;
   logic             s_blk_ready;
   logic [511:0]     s_blk_data;
   logic             s_blk_first;
   logic             s_blk_last;
   logic             core_start;
   logic             core_init;
   logic [511:0]     core_block;
   logic             core_done;
   logic [255:0]     core_digest;
   logic             m_dig_valid;
   logic             m_dig_ready;
   logic [255:0]     m_dig_data;
   logic [CNT_W-1:0] blk_count;
   logic             busy;
   logic             err_seq;
   logic             timeout;

   sha256_block_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .aclk        (aclk),
      .areset      (areset),
      .s_blk_valid (s_blk_valid),
      .s_blk_ready (s_blk_ready),
      .s_blk_data  (s_blk_data),
      .s_blk_first (s_blk_first),
      .s_blk_last  (s_blk_last),
      .core_start  (core_start),
      .core_init   (core_init),
      .core_block  (core_block),
      .core_done   (core_done),
      .core_digest (core_digest),
      .m_dig_valid (m_dig_valid),
      .m_dig_ready (m_dig_ready),
      .m_dig_data  (m_dig_data),
      .blk_count   (blk_count),
      .busy        (busy),
      .err_seq     (err_seq),
      .timeout     (timeout)
   );

   always #5 aclk = ~aclk;

   int           errors = 0;
   int           checks = 0;
   logic [255:0] core_chain  = '0;  // chaining value held by the modelled core
   logic [255:0] pending_res = '0;  // result the modelled core will report

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
         s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      {a, b, c, d, e, f, g, hh} = h;
      for (int i = 0; i < 64; i++) begin
         t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
              h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
   endfunction

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_blk_ready"}, s_blk_ready, 0);
      check({tag, "_core_start"},  core_start, 0);
      check({tag, "_core_init"},   core_init, 0);
      check({tag, "_core_block"},  core_block, 0);
      check({tag, "_m_dig_valid"}, m_dig_valid, 0);
      check({tag, "_m_dig_data"},  m_dig_data, 0);
      check({tag, "_blk_count"},   blk_count, 0);
      check({tag, "_busy"},        busy, 0);
      check({tag, "_err_seq"},     err_seq, 0);
      check({tag, "_timeout"},     timeout, 0);
   endtask

   // Hands one block over and checks the start pulse; returns at the first WAIT-cycle negedge.
   task automatic issue_block(input logic [511:0] blk, input bit first, input bit last, input bit exp_init);
      int n;
      @(negedge aclk);
      s_blk_valid = 1'b1; s_blk_data = blk; s_blk_first = first; s_blk_last = last;
      n = 0;
      while (s_blk_ready !== 1'b1 && n < 50) begin
         @(negedge aclk);
         n++;
      end
      check("blk_ready_wait_ok", (n < 50), 1);
      @(posedge aclk);
      #1 s_blk_valid = 1'b0;
      @(negedge aclk);
      check("core_start_pulse", core_start, 1);
      check("core_init", core_init, exp_init);
      check("core_block", core_block, blk);
      check("blk_ready_low_in_start", s_blk_ready, 0);
      pending_res = sha_compress(core_init ? IV : core_chain, core_block);
      @(negedge aclk);
      check("core_start_single", core_start, 0);
      check("busy_in_wait", busy, 1);
   endtask

   // Core reports pending_res after lat WAIT cycles (lat >= 1).
   task automatic finish_block(input int lat);
      repeat (lat - 1) @(negedge aclk);
      core_digest = pending_res;
      core_done   = 1'b1;
      @(negedge aclk);
      core_done   = 1'b0;
      core_digest = ~pending_res;
      core_chain  = pending_res;
   endtask

   task automatic send_block(input logic [511:0] blk, input bit first, input bit last,
                             input bit exp_init, input int lat);
      issue_block(blk, first, last, exp_init);
      finish_block(lat);
      if (!last) begin
         check("mid_msg_no_digest", m_dig_valid, 0);
         check("mid_msg_idle", busy, 0);
      end
   endtask

   task automatic get_digest(input string tag, input logic [255:0] exp, input int exp_cnt, input int stall);
      int           n;
      logic [255:0] held;
      n = 0;
      while (m_dig_valid !== 1'b1 && n < 50) begin
         @(negedge aclk);
         n++;
      end
      check({tag, "_valid"}, m_dig_valid, 1);
      check({tag, "_digest"}, m_dig_data, exp);
      check({tag, "_count"}, blk_count, exp_cnt);
      held = m_dig_data;
      for (int i = 0; i < stall; i++) begin
         @(negedge aclk);
         check({tag, "_stall_valid"}, m_dig_valid, 1);
         check({tag, "_stall_data"}, m_dig_data, held);
         check({tag, "_stall_blk_ready"}, s_blk_ready, 0);
      end
      m_dig_ready = 1'b1;
      @(negedge aclk);
      m_dig_ready = 1'b0;
      check({tag, "_valid_drop"}, m_dig_valid, 0);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_count_hold"}, blk_count, exp_cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int           nb;
      logic [255:0] exp_h;
      logic [511:0] blk;
      logic [511:0] blk_a;

      areset = 1'b1; s_blk_valid = 1'b0; s_blk_data = '0; s_blk_first = 1'b0; s_blk_last = 1'b0;
      core_done = 1'b0; core_digest = '0; m_dig_ready = 1'b0;
      repeat (3) @(negedge aclk);
      check_reset_outputs("reset");
      areset = 1'b0;

      // Known vectors
      send_block(ABC_BLK, 1, 1, 1, 3);
      get_digest("abc", ABC_DIG, 1, 0);
      check("abc_err_seq", err_seq, 0);
      send_block(EMPTY_BLK, 1, 1, 1, 1);
      get_digest("empty", EMPTY_DIG, 1, 0);
      send_block(TWO_BLK0, 1, 0, 1, 2);
      check("two_count_mid", blk_count, 1);
      send_block(TWO_BLK1, 0, 1, 0, 4);
      get_digest("two", TWO_DIG, 2, 0);

      // Digest back-pressure for 20 cycles
      send_block(ABC_BLK, 1, 1, 1, 1);
      get_digest("stall", ABC_DIG, 1, 20);

      // Random multi-block messages against the message-level model
      for (int m = 0; m < 6; m++) begin
         nb    = $urandom_range(1, 4);
         exp_h = IV;
         for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < 16; w++) blk[32*w +: 32] = $urandom;
            exp_h = sha_compress(exp_h, blk);
            send_block(blk, (b == 0), (b == nb - 1), (b == 0), $urandom_range(1, 5));
            if (b != nb - 1) check("rand_count_mid", blk_count, b + 1);
         end
         get_digest("rand", exp_h, nb, $urandom_range(0, 3));
      end
      check("rand_err_seq", err_seq, 0);

      // Stray core_done while IDLE with a chain open is ignored
      for (int w = 0; w < 16; w++) blk_a[32*w +: 32] = $urandom;
      for (int w = 0; w < 16; w++) blk[32*w +: 32] = $urandom;
      send_block(blk_a, 1, 0, 1, 2);
      @(negedge aclk);
      core_digest = {8{32'hdeadbeef}}; core_done = 1'b1;
      @(negedge aclk);
      core_done = 1'b0;
      check("stray_busy", busy, 0);
      check("stray_valid", m_dig_valid, 0);
      check("stray_count", blk_count, 1);
      send_block(blk, 0, 1, 0, 3);
      get_digest("stray", sha_compress(sha_compress(IV, blk_a), blk), 2, 1);

      // first=1 while a chain is open: error, chain restarts from the IV
      send_block(blk_a, 1, 0, 1, 1);
      check("reopen_err_before", err_seq, 0);
      send_block(blk, 1, 1, 1, 2);
      check("reopen_err_seq", err_seq, 1);
      get_digest("reopen", sha_compress(IV, blk), 1, 0);

      // Reset while in WAIT, then a late core_done
      issue_block(ABC_BLK, 1, 1, 1);
      areset = 1'b1;
      @(negedge aclk);
      check_reset_outputs("wait_reset");
      @(negedge aclk);
      areset = 1'b0;
      core_digest = ABC_DIG; core_done = 1'b1;
      @(negedge aclk);
      core_done = 1'b0;
      check("late_done_busy", busy, 0);
      check("late_done_valid", m_dig_valid, 0);
      check("late_done_count", blk_count, 0);
      check("late_done_ready", s_blk_ready, 1);

      // first=0 straight after reset: error, treated as first
      send_block(ABC_BLK, 0, 1, 1, 2);
      check("nofirst_err_seq", err_seq, 1);
      get_digest("nofirst", ABC_DIG, 1, 0);

      // Long wait for core_done
      issue_block(ABC_BLK, 1, 1, 1);
`ifdef SEQ_TIMEOUT_EN
      repeat (TB_TIMEOUT - 1) @(negedge aclk);
      check("to_before_busy", busy, 1);
      check("to_before_flag", timeout, 0);
      @(negedge aclk);
      check("to_flag", timeout, 1);
      check("to_idle", busy, 0);
      repeat (3) @(negedge aclk);
      check("to_no_digest", m_dig_valid, 0);
      check("to_flag_sticky", timeout, 1);
`else
      repeat (3 * TB_TIMEOUT) @(negedge aclk);
      check("long_wait_busy", busy, 1);
      check("long_wait_timeout", timeout, 0);
      check("long_wait_no_digest", m_dig_valid, 0);
      finish_block(1);
      get_digest("long_wait", ABC_DIG, 1, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
